// File: rtl/mcd_tx_feeder.sv
// Feeds producer words through a small FIFO to a slow transmit adapter.
// Handshakes with the adapter purely through its (asynchronous) idle flag.
module mcd_tx_feeder #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             adp_available,
    output logic             adp_start_tx,
    output logic [WIDTH-1:0] adp_dat_in,
    output logic             busy,
    output logic [15:0]      sent_count,
    output logic [7:0]       retry_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [7:0]    TmoLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAccept, StWaitDone} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             avail_q, avail_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [15:0]      sent_q, sent_d;
    logic [7:0]       retry_q, retry_d;
    logic             start_q, start_d;
    logic             push, pop;

    assign in_ready     = (count_q < DepthC);
    assign adp_dat_in   = mem_q[rd_ptr_q];
    assign adp_start_tx = start_q;
    assign busy         = (count_q != '0) || (state_q != StIdle);
    assign sent_count   = sent_q;
    assign retry_count  = retry_q;

    // avail_q is the synchronised idle flag; nothing else looks at adp_available.
    always_comb begin
        sync1_d = adp_available;
        avail_d = sync1_q;
    end

    always_comb begin
        pop     = 1'b0;
        state_d = state_q;
        tmo_d   = tmo_q;
        sent_d  = sent_q;
        retry_d = retry_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0 && avail_q) state_d = StIssue;
            end
            StIssue: begin
                state_d = StWaitAccept;
                tmo_d   = '0;
            end
            StWaitAccept: begin
                // Adapter dropping its idle flag means it latched the head word.
                if (!avail_q) begin
                    pop     = 1'b1;
                    state_d = StWaitDone;
                end else if (tmo_q == TmoLast) begin
                    state_d = StIssue;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StWaitDone: begin
                if (avail_q) begin
                    sent_d  = sent_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        start_d = (state_d == StIssue);
    end

    always_comb begin
        push     = in_valid && in_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sync1_q  <= 1'b0;
            avail_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tmo_q    <= '0;
            sent_q   <= '0;
            retry_q  <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            avail_q  <= avail_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tmo_q    <= tmo_d;
            sent_q   <= sent_d;
            retry_q  <= retry_d;
            start_q  <= start_d;
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
